// File: rtl/bus_master_port_if.sv
// Command/bus signal bundle for bus_master_port: local-master command side plus serial bus side.
// The master modport is the port block itself; slave is the environment (local master, arbiter, slave).
interface bus_master_port_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic [ADDR_W-1:0] M_ADDR;
  logic [DATA_W-1:0] M_DIN;
  logic              M_RW;
  logic              M_EXECUTE;
  logic              M_HOLD;
  logic [DATA_W-1:0] M_DOUT;
  logic              M_DVALID;
  logic              M_BSY;
  logic              M_ERR;
  logic              B_REQ;
  logic              B_GRANT;
  logic              B_UTIL;
  logic              B_RW;
  logic              B_BUS_OUT;
  logic              B_BUS_IN;
  logic              B_ACK;

  modport master (
    input  M_ADDR, M_DIN, M_RW, M_EXECUTE, M_HOLD, B_GRANT, B_BUS_IN, B_ACK,
    output M_DOUT, M_DVALID, M_BSY, M_ERR, B_REQ, B_UTIL, B_RW, B_BUS_OUT
  );

  modport slave (
    output M_ADDR, M_DIN, M_RW, M_EXECUTE, M_HOLD, B_GRANT, B_BUS_IN, B_ACK,
    input  M_DOUT, M_DVALID, M_BSY, M_ERR, B_REQ, B_UTIL, B_RW, B_BUS_OUT
  );
endinterface

// File: rtl/bus_master_port.sv
// Serial bus master port: arbitrates, shifts address/write data out LSB first, collects acks and read data.
// Optional ACK timeout abort is compiled in with `define BUS_TIMEOUT_EN.
module bus_master_port #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ACK_TIMEOUT = 32
) (
  input  logic              CLK,
  input  logic              RSTN,
  bus_master_port_if.master bus
);

  localparam int unsigned CNT_MAX_AD = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned CNT_MAX    = (CNT_MAX_AD > ACK_TIMEOUT) ? CNT_MAX_AD : ACK_TIMEOUT;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ADDR, S_ACKA, S_WDATA, S_ACKW, S_RDATA, S_DONE
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_sh_q;
  logic [DATA_W-1:0] din_sh_q;
  logic [DATA_W-1:0] rd_sh_q;
  logic [DATA_W-1:0] dout_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              rw_q;
  logic              held_q;
  logic              bsy_q;
  logic              req_q;
  logic              util_q;
  logic              brw_q;
  logic              bout_q;
  logic              dvalid_q;
  logic [DATA_W-1:0] rd_sh_d;

  // Read data arrives LSB first, so new bits enter at the top and drift down.
  assign rd_sh_d = {bus.B_BUS_IN, rd_sh_q[DATA_W-1:1]};

`ifdef BUS_TIMEOUT_EN
  logic err_q;
  logic ack_expired_c;
  assign ack_expired_c = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
`endif

  always_ff @(posedge CLK) begin
    if (RSTN) begin
      state_q   <= S_IDLE;
      addr_sh_q <= '0;
      din_sh_q  <= '0;
      rd_sh_q   <= '0;
      dout_q    <= '0;
      cnt_q     <= '0;
      rw_q      <= 1'b0;
      held_q    <= 1'b0;
      bsy_q     <= 1'b0;
      req_q     <= 1'b0;
      util_q    <= 1'b0;
      brw_q     <= 1'b0;
      bout_q    <= 1'b0;
      dvalid_q  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      dvalid_q <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (bus.M_EXECUTE) begin
            din_sh_q <= bus.M_DIN;
            rw_q     <= bus.M_RW;
            bsy_q    <= 1'b1;
            req_q    <= 1'b1;
            cnt_q    <= '0;
            // A retained grant lets the first address bit go out immediately.
            if (held_q) begin
              state_q   <= S_ADDR;
              util_q    <= 1'b1;
              brw_q     <= bus.M_RW;
              bout_q    <= bus.M_ADDR[0];
              addr_sh_q <= bus.M_ADDR >> 1;
            end else begin
              state_q   <= S_REQ;
              addr_sh_q <= bus.M_ADDR;
            end
          end
        end
        S_REQ: begin
          if (bus.B_GRANT) begin
            state_q   <= S_ADDR;
            util_q    <= 1'b1;
            brw_q     <= rw_q;
            bout_q    <= addr_sh_q[0];
            addr_sh_q <= addr_sh_q >> 1;
            cnt_q     <= '0;
          end
        end
        S_ADDR: begin
          if (cnt_q == CNT_W'(ADDR_W - 1)) begin
            state_q <= S_ACKA;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q     <= cnt_q + CNT_W'(1);
            bout_q    <= addr_sh_q[0];
            addr_sh_q <= addr_sh_q >> 1;
          end
        end
        S_ACKA: begin
          if (bus.B_ACK) begin
            cnt_q <= '0;
            if (rw_q) begin
              state_q  <= S_WDATA;
              bout_q   <= din_sh_q[0];
              din_sh_q <= din_sh_q >> 1;
            end else begin
              state_q  <= S_RDATA;
            end
          end
        end
        S_WDATA: begin
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_q <= S_ACKW;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q    <= cnt_q + CNT_W'(1);
            bout_q   <= din_sh_q[0];
            din_sh_q <= din_sh_q >> 1;
          end
        end
        S_ACKW: begin
          if (bus.B_ACK) begin
            state_q <= S_DONE;
          end
        end
        S_RDATA: begin
          rd_sh_q <= rd_sh_d;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_q  <= S_DONE;
            dout_q   <= rd_sh_d;
            dvalid_q <= 1'b1;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          bsy_q   <= 1'b0;
          util_q  <= 1'b0;
          brw_q   <= 1'b0;
          held_q  <= bus.M_HOLD;
          req_q   <= bus.M_HOLD;
        end
        default: state_q <= S_IDLE;
      endcase
`ifdef BUS_TIMEOUT_EN
      // Ack wait watchdog; overrides the case above when it fires.
      if ((state_q == S_ACKA || state_q == S_ACKW) && !bus.B_ACK) begin
        if (ack_expired_c) begin
          state_q <= S_IDLE;
          err_q   <= 1'b1;
          bsy_q   <= 1'b0;
          req_q   <= 1'b0;
          util_q  <= 1'b0;
          brw_q   <= 1'b0;
          bout_q  <= 1'b0;
          held_q  <= 1'b0;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
`endif
    end
  end

  assign bus.M_DOUT    = dout_q;
  assign bus.M_DVALID  = dvalid_q;
  assign bus.M_BSY     = bsy_q;
  assign bus.B_REQ     = req_q;
  assign bus.B_UTIL    = util_q;
  assign bus.B_RW      = brw_q;
  assign bus.B_BUS_OUT = bout_q;
`ifdef BUS_TIMEOUT_EN
  assign bus.M_ERR     = err_q;
`else
  assign bus.M_ERR     = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: transactions expand into per-cycle stimulus/expected-output queues,
// played back and compared every cycle, plus literal latency/bit-order expectations.
module tb_bus_master_port;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int          ACK_TO = 32;

  logic clk = 1'b0;
  logic rst;

  bus_master_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  bus_master_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACK_TIMEOUT(ACK_TO)) dut (
    .CLK (clk),
    .RSTN(rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        exec;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        rw;
    logic        hold;
    logic        grant;
    logic        ack;
    logic        bus_in;
    logic        rst;
  } stim_t;

  typedef struct packed {
    logic       bsy;
    logic       req;
    logic       util;
    logic       brw;
    logic       bout;
    logic       dvalid;
    logic       err;
    logic [7:0] dout;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  exp_t  expv;
  bit    chk_en = 1'b0;
  int    cur = 0;
  int    n_pushed = 0;
  int    n_played = 0;
  int    n_checks = 0;
  int    n_err = 0;

  // Transaction-level model state: retained grant and last read data.
  logic       m_held = 1'b0;
  logic [7:0] m_dout = 8'h00;

  bit   mon_on = 1'b0;
  int   mon_mark = 0;
  int   dv_at = -1;
  int   bf_at = -1;
  int   er_at = -1;
  int   ncap = 0;
  logic cap [64];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cur, act, exp);
    end
  endtask

  function automatic stim_t rnd_stim(input bit busy);
    stim_t s;
    s.exec   = busy ? 1'($urandom_range(0, 1)) : 1'b0;
    s.addr   = 16'($urandom);
    s.din    = 8'($urandom);
    s.rw     = 1'($urandom_range(0, 1));
    s.hold   = 1'($urandom_range(0, 1));
    s.grant  = 1'($urandom_range(0, 1));
    s.ack    = 1'($urandom_range(0, 1));
    s.bus_in = 1'($urandom_range(0, 1));
    s.rst    = 1'b0;
    return s;
  endfunction

  function automatic exp_t idle_o();
    exp_t o = '0;
    o.req  = m_held;
    o.dout = m_dout;
    return o;
  endfunction

  function automatic exp_t busy_o(input logic util, input logic rw, input logic bout);
    exp_t o = '0;
    o.bsy  = 1'b1;
    o.req  = 1'b1;
    o.util = util;
    o.brw  = util & rw;
    o.bout = bout;
    o.dout = m_dout;
    return o;
  endfunction

  task automatic push(input stim_t s, input exp_t o);
    stim_q.push_back(s);
    exp_q.push_back(o);
    n_pushed++;
  endtask

  task automatic idle(input int n);
    repeat (n) push(rnd_stim(1'b0), idle_o());
  endtask

  task automatic ack_phase(input int wait_n, input logic rw);
    stim_t s;
    for (int i = 0; i <= wait_n; i++) begin
      s     = rnd_stim(1'b1);
      s.ack = (i == wait_n);
      push(s, busy_o(1'b1, rw, 1'b0));
    end
  endtask

  // Expand one transaction into cycles, starting with the execute cycle.
  task automatic build(input logic [15:0] addr, input logic [7:0] din, input logic rw,
                       input logic hold, input int gd, input int a1, input int a2,
                       input logic [7:0] rd, input int rst_bit, input bit no_ack);
    stim_t s;
    exp_t  o;
    s      = rnd_stim(1'b0);
    s.exec = 1'b1;
    s.addr = addr;
    s.din  = din;
    s.rw   = rw;
    push(s, idle_o());
    if (!m_held) begin
      for (int i = 0; i <= gd; i++) begin
        s       = rnd_stim(1'b1);
        s.grant = (i == gd);
        push(s, busy_o(1'b0, rw, 1'b0));
      end
    end
    for (int k = 0; k < int'(ADDR_W); k++) begin
      s = rnd_stim(1'b1);
      o = busy_o(1'b1, rw, addr[k]);
      if (k == rst_bit) begin
        s.rst = 1'b1;
        push(s, o);
        m_held = 1'b0;
        m_dout = 8'h00;
        return;
      end
      push(s, o);
    end
    if (no_ack) begin
`ifdef BUS_TIMEOUT_EN
      for (int i = 0; i < ACK_TO; i++) begin
        s     = rnd_stim(1'b1);
        s.ack = 1'b0;
        push(s, busy_o(1'b1, rw, 1'b0));
      end
      m_held = 1'b0;
      o      = idle_o();
      o.err  = 1'b1;
      push(rnd_stim(1'b0), o);
`else
      for (int i = 0; i < ACK_TO + 8; i++) begin
        s     = rnd_stim(1'b1);
        s.ack = 1'b0;
        push(s, busy_o(1'b1, rw, 1'b0));
      end
      s     = rnd_stim(1'b1);
      s.ack = 1'b0;
      s.rst = 1'b1;
      push(s, busy_o(1'b1, rw, 1'b0));
      m_held = 1'b0;
      m_dout = 8'h00;
`endif
      return;
    end
    ack_phase(a1, rw);
    if (rw) begin
      for (int k = 0; k < int'(DATA_W); k++) push(rnd_stim(1'b1), busy_o(1'b1, rw, din[k]));
      ack_phase(a2, rw);
    end else begin
      for (int k = 0; k < int'(DATA_W); k++) begin
        s        = rnd_stim(1'b1);
        s.bus_in = rd[k];
        push(s, busy_o(1'b1, rw, 1'b0));
      end
    end
    s      = rnd_stim(1'b1);
    s.hold = hold;
    o      = busy_o(1'b1, rw, 1'b0);
    if (!rw) begin
      o.dvalid = 1'b1;
      o.dout   = rd;
      m_dout   = rd;
    end
    push(s, o);
    m_held = hold;
  endtask

  task automatic drive(input stim_t s);
    rst           = s.rst;
    bus.M_EXECUTE = s.exec;
    bus.M_ADDR    = s.addr;
    bus.M_DIN     = s.din;
    bus.M_RW      = s.rw;
    bus.M_HOLD    = s.hold;
    bus.B_GRANT   = s.grant;
    bus.B_ACK     = s.ack;
    bus.B_BUS_IN  = s.bus_in;
  endtask

  task automatic play();
    while (stim_q.size() > 0) begin
      stim_t s;
      exp_t  o;
      s = stim_q.pop_front();
      o = exp_q.pop_front();
      @(posedge clk);
      #1;
      drive(s);
      expv     = o;
      cur      = n_played;
      n_played++;
      chk_en   = 1'b1;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic arm();
    mon_on   = 1'b1;
    mon_mark = n_pushed;
    dv_at    = -1;
    bf_at    = -1;
    er_at    = -1;
    ncap     = 0;
  endtask

  // Per-cycle comparison against the model, plus event capture for the literal checks.
  always @(negedge clk) begin
    if (chk_en) begin
      check("M_BSY",     32'(bus.M_BSY),     32'(expv.bsy));
      check("B_REQ",     32'(bus.B_REQ),     32'(expv.req));
      check("B_UTIL",    32'(bus.B_UTIL),    32'(expv.util));
      check("B_RW",      32'(bus.B_RW),      32'(expv.brw));
      check("B_BUS_OUT", 32'(bus.B_BUS_OUT), 32'(expv.bout));
      check("M_DVALID",  32'(bus.M_DVALID),  32'(expv.dvalid));
      check("M_ERR",     32'(bus.M_ERR),     32'(expv.err));
      check("M_DOUT",    32'(bus.M_DOUT),    32'(expv.dout));
      if (mon_on && cur > mon_mark) begin
        if (bus.B_UTIL && ncap < 64) begin
          cap[ncap] = bus.B_BUS_OUT;
          ncap++;
        end
        if (bus.M_DVALID && dv_at < 0) dv_at = cur - mon_mark;
        if (!bus.M_BSY && bf_at < 0) bf_at = cur - mon_mark;
        if (bus.M_ERR && er_at < 0) er_at = cur - mon_mark;
      end
    end
  end

  initial begin
    stim_t       s0;
    logic [15:0] a_bits;
    logic [7:0]  d_bits;
    s0     = '0;
    s0.rst = 1'b1;
    drive(s0);

    for (int i = 0; i < 3; i++) begin
      s0     = rnd_stim(1'b0);
      s0.rst = 1'b1;
      push(s0, idle_o());
    end
    idle(2);
    play();

    // Directed write, immediate grant and acks.
    arm();
    build(16'h0A5C, 8'h3C, 1'b1, 1'b0, 0, 0, 0, 8'h00, -1, 1'b0);
    idle(3);
    play();
    for (int k = 0; k < 16; k++) a_bits[k] = cap[k];
    for (int k = 0; k < 8; k++) d_bits[k] = cap[17 + k];
    check("wr_bsy_fall_cycle", 32'(bf_at), 32'd29);
    check("wr_no_dvalid", 32'(dv_at), 32'hFFFF_FFFF);
    check("wr_util_cycles", 32'(ncap), 32'd27);
    check("wr_addr_bits", 32'(a_bits), 32'h0A5C);
    check("wr_data_bits", 32'(d_bits), 32'h3C);

    // Directed read returning 0xA5.
    arm();
    build(16'h07FF, 8'h00, 1'b0, 1'b0, 0, 0, 0, 8'hA5, -1, 1'b0);
    idle(3);
    play();
    check("rd_dvalid_cycle", 32'(dv_at), 32'd27);
    check("rd_bsy_fall_cycle", 32'(bf_at), 32'd28);
    check("rd_dout_held", 32'(bus.M_DOUT), 32'hA5);

    // Grant withheld for 10 cycles.
    arm();
    build(16'h1234, 8'h5A, 1'b1, 1'b0, 10, 0, 0, 8'h00, -1, 1'b0);
    idle(2);
    play();
    check("arb_bsy_fall_cycle", 32'(bf_at), 32'd39);

    // Back-to-back writes with the grant held.
    build(16'hBEEF, 8'h11, 1'b1, 1'b1, 2, 1, 1, 8'h00, -1, 1'b0);
    idle(1);
    play();
    check("hold_req_between", 32'(bus.B_REQ), 32'd1);
    arm();
    build(16'hCAFE, 8'h22, 1'b1, 1'b0, 5, 0, 0, 8'h00, -1, 1'b0);
    idle(2);
    play();
    check("hold_skip_req_cycle", 32'(bf_at), 32'd28);

    // Reset during address bit 5, then a normal read.
    arm();
    build(16'hF0F0, 8'h77, 1'b1, 1'b0, 0, 0, 0, 8'h00, 5, 1'b0);
    idle(2);
    play();
    check("rst_bsy_fall_cycle", 32'(bf_at), 32'd8);
    arm();
    build(16'h0101, 8'h00, 1'b0, 1'b0, 0, 0, 0, 8'h3E, -1, 1'b0);
    idle(2);
    play();
    check("post_rst_dvalid_cycle", 32'(dv_at), 32'd27);

    // Acks arriving on the last cycle before the timeout would fire.
    arm();
    build(16'h4321, 8'h99, 1'b1, 1'b0, 0, ACK_TO - 1, ACK_TO - 1, 8'h00, -1, 1'b0);
    idle(2);
    play();
    check("late_ack_bsy_fall_cycle", 32'(bf_at), 32'(29 + 2 * (ACK_TO - 1)));

    // Slave never acknowledges the address.
    arm();
    build(16'h5555, 8'hAA, 1'b1, 1'b1, 0, 0, 0, 8'h00, -1, 1'b1);
    idle(3);
    play();
`ifdef BUS_TIMEOUT_EN
    check("timeout_err_cycle", 32'(er_at), 32'd50);
    check("timeout_bsy_fall_cycle", 32'(bf_at), 32'd50);
`else
    check("no_timeout_err", 32'(er_at), 32'hFFFF_FFFF);
    check("no_timeout_bsy_fall_cycle", 32'(bf_at), 32'(18 + ACK_TO + 8 + 1));
`endif
    mon_on = 1'b0;

    // Randomized transactions with stray inputs.
    for (int t = 0; t < 40; t++) begin
      build(16'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
            8'($urandom), -1, 1'b0);
      idle(int'($urandom_range(0, 3)));
    end
    play();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
- Master-side serial bus interface that sits directly upstream of the 2K slave port.
- Accepts a parallel read/write command from the local master: address, data, RW and execute.
- Arbitrates for the shared bus, then serializes address and write data onto B_BUS_OUT.
- Collects slave acknowledges and deserializes read data from B_BUS_IN back to the master.

Parameters:
- ADDR_W, 16, address bits shifted per transaction, LSB first.
- DATA_W, 8, data bits shifted per transaction, LSB first.
- ACK_TIMEOUT, 32, cycles to wait for B_ACK before abort. Only used when BUS_TIMEOUT_EN is defined.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RSTN  in  1  synchronous, active-high reset (RSTN=1 resets on the next posedge).
- M_ADDR  in  ADDR_W  transaction address.
- M_DIN  in  DATA_W  write data.
- M_RW  in  1  1=write, 0=read.
- M_EXECUTE  in  1  start request; sampled only when M_BSY=0.
- M_HOLD  in  1  keep the bus granted after completion, for back-to-back transactions.
- M_DOUT  out  DATA_W  read data; valid while M_DVALID=1, held until the next read.
- M_DVALID  out  1  one-cycle pulse when read data is ready.
- M_BSY  out  1  transaction in progress.
- M_ERR  out  1  one-cycle pulse on ACK timeout (constant 0 when the feature is compiled out).
- B_REQ  out  1  bus request to the arbiter.
- B_GRANT  in  1  bus grant from the arbiter.
- B_UTIL  out  1  bus in use; high from the first address bit through completion.
- B_RW  out  1  transaction direction, valid while B_UTIL=1.
- B_BUS_OUT  out  1  serial master-to-slave line.
- B_BUS_IN  in  1  serial slave-to-master line.
- B_ACK  in  1  slave acknowledge.

Behaviour:
- Reset values: all outputs 0. State=IDLE, counters 0, shift registers 0, M_DOUT=0.
- States: IDLE, REQ, ADDR, ACKA, WDATA, ACKW, RDATA, DONE.
- IDLE:
  - M_EXECUTE=1 latches M_ADDR, M_DIN and M_RW.
  - M_BSY=1 from the next cycle.
  - Goes to ADDR if the grant is already held (via M_HOLD), otherwise to REQ.
  - M_EXECUTE while M_BSY=1 is ignored.
- REQ:
  - B_REQ=1.
  - Stays until B_GRANT=1 is sampled, then goes to ADDR.
- ADDR:
  - B_UTIL=1, B_RW=latched RW.
  - B_BUS_OUT drives address bit k in the k-th ADDR cycle, k=0..ADDR_W-1; exactly ADDR_W cycles.
  - Then goes to ACKA.
- ACKA:
  - B_BUS_OUT=0.
  - Waits for B_ACK=1.
  - On ACK goes to WDATA if write, RDATA if read.
- WDATA:
  - DATA_W cycles, data bit k in cycle k.
  - Then goes to ACKW.
- ACKW: waits for B_ACK=1, then goes to DONE.
- RDATA:
  - Samples B_BUS_IN on each of the DATA_W cycles following the ACKA acknowledge; the first sample is bit 0.
  - After the last sample: M_DOUT updates and M_DVALID=1 for exactly the following cycle (the DONE cycle).
- DONE:
  - B_UTIL=0 and M_BSY=0 from the next cycle.
  - If M_HOLD=1 in DONE, B_REQ stays 1 and the grant is retained for the next execute.
  - Otherwise B_REQ drops and the next transaction goes through REQ.
- Latency with immediate grant and acknowledge, execute sampled at edge 0:
  - Write: M_BSY falls after 2+ADDR_W+1+DATA_W+1+1 cycles (29 with defaults).
  - Read: M_DVALID is high in cycle 2+ADDR_W+1+DATA_W (27).
- Stray inputs:
  - B_ACK outside ACKA/ACKW is ignored.
  - B_GRANT dropping mid-transaction is ignored; the transaction completes.
- B_RW and the latched values are stable for the whole transaction, independent of M_* input changes.
- Reset mid-transaction: all outputs return to 0 the next cycle, including B_UTIL, B_REQ and M_BSY. Partial shift data is discarded.
- Counters must be wide enough for max(ADDR_W, DATA_W, ACK_TIMEOUT) and must not wrap during a phase.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - In ACKA/ACKW, a counter starts at 0 on state entry and increments each cycle without ACK.
  - When it reaches ACK_TIMEOUT, the transaction aborts: M_ERR pulses 1 cycle, M_DVALID stays 0.
  - B_UTIL and B_REQ drop the next cycle, ignoring M_HOLD.
  - M_BSY falls with them; state returns to IDLE.
- Undefined: no counter, waits indefinitely, M_ERR tied 0.

Test Plan:
- Write: execute with ADDR=0x0A5C, DIN=0x3C, RW=1; grant and both ACKs immediate -> B_BUS_OUT carries 0x0A5C LSB-first then 0x3C LSB-first, B_RW=1; M_BSY=0 after 29 cycles; M_DVALID never asserted.
- Read: ADDR=0x07FF, RW=0; slave drives 0xA5 LSB-first after ACK -> M_DOUT=0xA5 with a single-cycle M_DVALID pulse; B_RW=0 throughout.
- Arbitration: B_GRANT withheld 10 cycles -> B_REQ high, B_UTIL low for 10 cycles, address shifting starts the cycle after grant; a second M_EXECUTE while busy is ignored.
- Hold: M_HOLD=1, two back-to-back writes -> B_REQ stays high between them and the second transaction skips REQ.
- Reset: RSTN=1 during bit 5 of the address -> all outputs 0 next cycle; a new transaction afterwards completes normally.
- With BUS_TIMEOUT_EN and ACK_TIMEOUT=32: B_ACK never asserted -> M_ERR pulses 32 cycles after ACKA entry, B_UTIL/B_REQ/M_BSY drop; without the macro, the block stays in ACKA with M_BSY=1.
